uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Bus-master sequencer that shares one memory-mapped UART transmitter between NUM_REQ byte-stream requesters.
- Round-robin arbitration over the requesters; the granted byte is sent by writing the UART TX data register, then pulsing tx_enable through the control register.
- Completion is detected by polling the tx event flag, which is then cleared.
- Sits between on-chip byte producers (debug, logger, CPU mailbox) and the UART slave port on the system bus.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BASE_ADDRESS, 32'h0, UART base byte address.
- CONTROL_OFFSET, 32'h0, control register byte offset.
- DIVISION_OFFSET, 32'h4, division register byte offset.
- TX_DATA_OFFSET, 32'h8, TX data register byte offset.
- DIVISION, 32'd0, value written to the division register after reset.
- TX_ENABLE_MASK, 32'h1, control bit that starts a frame.
- TX_EVENT_MASK, 32'h4, control bit set by the UART when a frame completes.
- POLL_LIMIT, 32'd65535, polls before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a byte
- req_data  in  8*NUM_REQ  byte of requester i at [8i+:8]
- req_ready  out  NUM_REQ  one-hot pulse: byte of requester i accepted
- busy  out  1  high in every state except IDLE
- grant_id  out  $clog2(NUM_REQ)  requester currently served
- m_valid  out  1  bus request
- m_ready  in  1  bus transfer complete
- m_address  out  32  byte address
- m_wstrobe  out  4  byte enables; 0 = read
- m_wdata  out  32  write data
- m_rdata  in  32  read data, sampled when m_valid && m_ready
- error  out  1  one-cycle abort pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async, active-high):
  - state=INIT_DIV; m_valid=0, m_wstrobe=0, m_address=0, m_wdata=0.
  - req_ready=0, grant_id=0, busy=1, error=0.
  - rr_last=NUM_REQ-1, so requester 0 has first priority.
  - Reset asserted mid-transfer abandons the transfer at once. No bus cycle or req_ready is issued while reset is high.
- Bus rule:
  - m_valid, m_address, m_wstrobe and m_wdata are registered outputs.
  - They hold stable from assertion until the edge where m_valid && m_ready; the transfer completes at that edge.
  - m_valid may stay high into a back-to-back transfer. A zero-wait slave gives 1 transfer per cycle.
- States:
  - INIT_DIV: write DIVISION to BASE+DIVISION_OFFSET, wstrobe 4'hF; on completion -> IDLE.
  - IDLE:
    - m_valid=0.
    - If any req_valid: pick the first set index scanning rr_last+1 ... rr_last+NUM_REQ (mod NUM_REQ).
    - Same cycle, combinationally: req_ready[i]=1.
    - At the edge: latch byte, grant_id=i, rr_last=i, -> WR_DATA.
    - With no req_valid set, stay in IDLE.
  - WR_DATA: write {24'h0,byte} to BASE+TX_DATA_OFFSET, wstrobe 4'hF -> WR_CTRL.
  - WR_CTRL: write TX_ENABLE_MASK to BASE+CONTROL_OFFSET, wstrobe 4'hF -> POLL.
  - POLL: read BASE+CONTROL_OFFSET.
    - Completion with (m_rdata & TX_EVENT_MASK)!=0 -> CLR.
    - Otherwise reissue the read in the next cycle.
  - CLR: write 32'h0 to BASE+CONTROL_OFFSET (clears flags, leaves tx_enable low) -> IDLE.
- Timing:
  - Accept at cycle T.
  - Zero-wait slave: WR_DATA transfer at T+1, WR_CTRL at T+2, first POLL at T+3.
  - Next acceptance no earlier than the cycle after CLR completes.
- Requester rules:
  - A requester dropping req_valid before acceptance is ignored; no byte is lost or duplicated.
  - req_data is sampled only in the acceptance cycle.
  - All requesters valid continuously gives strict rotation 0,1,2,3,0...
- Stalled slave: states hold indefinitely (no timeout unless the optional feature is enabled).

Optional Feature:
- Macro UART_TX_SCHEDULER_POLL_TIMEOUT_EN.
- When defined:
  - A 32-bit poll counter is cleared on POLL entry and incremented on each completed POLL read without the event bit.
  - When it reaches POLL_LIMIT: error pulses high for 1 cycle and the state goes to CLR (byte dropped); arbitration then continues normally.
- When undefined: no counter, error tied 0, POLL waits forever.

Test Plan:
- Reset release, DIVISION=32'd10, m_ready=m_valid -> first transfer is a write of 32'd10 to 32'h4; busy drops the next cycle.
- req_valid=4'b0001, req_data[7:0]=8'h5A, slave sets event bit on the 3rd poll:
  - req_ready[0] pulses.
  - Writes 32'h5A to 32'h8, then 32'h1 to 32'h0.
  - 3 reads of 32'h0, then write 32'h0 to 32'h0; back in IDLE.
- req_valid=4'b1111 held through 8 frames -> grant order 0,1,2,3,0,1,2,3; exactly one req_ready bit per frame.
- Slave holds m_ready=0 for 5 cycles during WR_DATA -> m_address, m_wdata and m_valid stable all 5 cycles; exactly one data write.
- Reset asserted in POLL -> outputs reach reset values without a clock edge; after release the sequence restarts at INIT_DIV and grants requester 0 first.
- Macro defined, POLL_LIMIT=4, event bit never set -> 4 poll reads, error pulses 1 cycle, CLR write, then the next requester is served.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin sequencer that shares one memory-mapped UART transmitter between NUM_REQ byte requesters.
// Optional poll timeout: define UART_TX_SCHEDULER_POLL_TIMEOUT_EN.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ         = 4,
  parameter logic [31:0] BASE_ADDRESS    = 32'h0,
  parameter logic [31:0] CONTROL_OFFSET  = 32'h0,
  parameter logic [31:0] DIVISION_OFFSET = 32'h4,
  parameter logic [31:0] TX_DATA_OFFSET  = 32'h8,
  parameter logic [31:0] DIVISION        = 32'd0,
  parameter logic [31:0] TX_ENABLE_MASK  = 32'h1,
  parameter logic [31:0] TX_EVENT_MASK   = 32'h4,
  parameter logic [31:0] POLL_LIMIT      = 32'd65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [31:0]                m_address,
  output logic [3:0]                 m_wstrobe,
  output logic [31:0]                m_wdata,
  input  logic [31:0]                m_rdata,
  output logic                       error
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  localparam logic [31:0] CTRL_ADDR = BASE_ADDRESS + CONTROL_OFFSET;
  localparam logic [31:0] DIV_ADDR  = BASE_ADDRESS + DIVISION_OFFSET;
  localparam logic [31:0] DATA_ADDR = BASE_ADDRESS + TX_DATA_OFFSET;

  if (NUM_REQ < 2 || NUM_REQ > 8 || POLL_LIMIT == 32'd0) begin : g_param_check
    $error("uart_tx_scheduler: NUM_REQ must be 2..8 and POLL_LIMIT nonzero");
  end

  typedef enum logic [2:0] {
    S_INIT_DIV,
    S_IDLE,
    S_WR_DATA,
    S_WR_CTRL,
    S_POLL,
    S_CLR
  } state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  rr_last_q, rr_last_d;
  logic             m_valid_q, m_valid_d;
  logic [31:0]      m_address_q, m_address_d;
  logic [3:0]       m_wstrobe_q, m_wstrobe_d;
  logic [31:0]      m_wdata_q, m_wdata_d;
  logic             error_d;

  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic [ID_W-1:0]  pick_cand;
  logic [7:0]       pick_byte;
  logic             xfer_done;
  logic             to_clr;

`ifdef UART_TX_SCHEDULER_POLL_TIMEOUT_EN
  logic [31:0]      poll_cnt_q, poll_cnt_d;
  logic             error_q;
`endif

  assign xfer_done = m_valid_q && m_ready;
  assign pick_byte = req_data[{pick_idx, 3'b000} +: 8];

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      pick_cand = ID_W'((32'(rr_last_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[pick_cand]) begin
        pick_found = 1'b1;
        pick_idx   = pick_cand;
      end
    end
  end

  // Acceptance strobe is combinational so the requester sees it in the grant cycle.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && pick_found) begin
      req_ready[pick_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_last_d   = rr_last_q;
    m_valid_d   = m_valid_q;
    m_address_d = m_address_q;
    m_wstrobe_d = m_wstrobe_q;
    m_wdata_d   = m_wdata_q;
    error_d     = 1'b0;
    to_clr      = 1'b0;
`ifdef UART_TX_SCHEDULER_POLL_TIMEOUT_EN
    poll_cnt_d  = poll_cnt_q;
`endif

    unique case (state_q)
      S_INIT_DIV: begin
        if (!m_valid_q) begin
          m_valid_d   = 1'b1;
          m_address_d = DIV_ADDR;
          m_wstrobe_d = 4'hF;
          m_wdata_d   = DIVISION;
        end else if (xfer_done) begin
          state_d     = S_IDLE;
          m_valid_d   = 1'b0;
          m_wstrobe_d = 4'h0;
        end
      end

      S_IDLE: begin
        if (pick_found) begin
          state_d     = S_WR_DATA;
          grant_id_d  = pick_idx;
          rr_last_d   = pick_idx;
          m_valid_d   = 1'b1;
          m_address_d = DATA_ADDR;
          m_wstrobe_d = 4'hF;
          m_wdata_d   = {24'h0, pick_byte};
        end
      end

      S_WR_DATA: begin
        if (xfer_done) begin
          state_d     = S_WR_CTRL;
          m_address_d = CTRL_ADDR;
          m_wstrobe_d = 4'hF;
          m_wdata_d   = TX_ENABLE_MASK;
        end
      end

      S_WR_CTRL: begin
        if (xfer_done) begin
          state_d     = S_POLL;
          m_address_d = CTRL_ADDR;
          m_wstrobe_d = 4'h0;
          m_wdata_d   = 32'h0;
`ifdef UART_TX_SCHEDULER_POLL_TIMEOUT_EN
          poll_cnt_d  = 32'h0;
`endif
        end
      end

      // A read without the event bit simply leaves the same read request on the bus.
      S_POLL: begin
        if (xfer_done) begin
          if ((m_rdata & TX_EVENT_MASK) != 32'h0) begin
            to_clr = 1'b1;
          end else begin
`ifdef UART_TX_SCHEDULER_POLL_TIMEOUT_EN
            poll_cnt_d = poll_cnt_q + 32'd1;
            if (poll_cnt_d >= POLL_LIMIT) begin
              error_d = 1'b1;
              to_clr  = 1'b1;
            end
`endif
          end
          if (to_clr) begin
            state_d     = S_CLR;
            m_address_d = CTRL_ADDR;
            m_wstrobe_d = 4'hF;
            m_wdata_d   = 32'h0;
          end
        end
      end

      S_CLR: begin
        if (xfer_done) begin
          state_d     = S_IDLE;
          m_valid_d   = 1'b0;
          m_wstrobe_d = 4'h0;
        end
      end

      default: begin
        state_d     = S_INIT_DIV;
        m_valid_d   = 1'b0;
        m_wstrobe_d = 4'h0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT_DIV;
      busy_q      <= 1'b1;
      grant_id_q  <= '0;
      rr_last_q   <= ID_W'(NUM_REQ - 1);
      m_valid_q   <= 1'b0;
      m_address_q <= 32'h0;
      m_wstrobe_q <= 4'h0;
      m_wdata_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      grant_id_q  <= grant_id_d;
      rr_last_q   <= rr_last_d;
      m_valid_q   <= m_valid_d;
      m_address_q <= m_address_d;
      m_wstrobe_q <= m_wstrobe_d;
      m_wdata_q   <= m_wdata_d;
    end
  end

`ifdef UART_TX_SCHEDULER_POLL_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt_q <= 32'h0;
      error_q    <= 1'b0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
      error_q    <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
  assign m_valid   = m_valid_q;
  assign m_address = m_address_q;
  assign m_wstrobe = m_wstrobe_q;
  assign m_wdata   = m_wdata_q;

endmodule
